// File: rtl/rsv_station_queue_pkg.sv
// Shared definitions for the reservation-station queue.
// Optional feature macro: RSQ_CDB_WAKEUP_BYPASS_EN (zero-cycle CDB wakeup).
// The entry struct itself is declared inside rsv_station_queue, because its
// field widths follow that module's parameters.
package rsv_station_queue_pkg;

  localparam int RSQ_MAX_DEPTH = 16;
  localparam int RSQ_MIN_DEPTH = 2;

  // An operand snoops the CDB only while it is still waiting on its producer.
  function automatic logic rsq_snoop_hit(input logic op_valid,
                                         input logic tag_eq,
                                         input logic cdb_valid);
    return cdb_valid & ~op_valid & tag_eq;
  endfunction

endpackage

// File: rtl/rsv_station_queue_picker.sv
// rsq_oldest_ready_picker: selects the lowest-index (oldest) ready entry.
// Purely combinational; returns a one-hot grant, the binary index and an any flag.
module rsq_oldest_ready_picker
  import rsv_station_queue_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     ready_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Priority scan from index 0; the first ready entry wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (ready_i[i] && !any_o) begin
        grant_o[i] = 1'b1;
        idx_o      = IDX_W'(i);
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rsv_station_queue.sv
// Reservation-station queue: age-ordered entries, CDB operand snooping,
// oldest-ready issue with collapse of younger entries.
// Optional feature macro: RSQ_CDB_WAKEUP_BYPASS_EN -- when defined, a CDB
// broadcast this cycle counts toward readiness and its data is forwarded
// to the issue outputs; when undefined, wakeup takes one cycle.
module rsv_station_queue
  import rsv_station_queue_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int TAG_W     = 6,
  parameter int DATA_W    = 32,
  parameter int PAYLOAD_W = 17
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         dispatch_en,
  input  logic [PAYLOAD_W-1:0]         dispatch_payload,
  input  logic [DATA_W-1:0]            dispatch_rs1_data,
  input  logic [DATA_W-1:0]            dispatch_rs2_data,
  input  logic                         dispatch_rs1_valid,
  input  logic                         dispatch_rs2_valid,
  input  logic [TAG_W-1:0]             dispatch_rs1_tag,
  input  logic [TAG_W-1:0]             dispatch_rs2_tag,
  input  logic [TAG_W-1:0]             dispatch_rd_tag,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [DATA_W-1:0]            cdb_result,
  output logic                         queue_full,
  output logic                         queue_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         issue_rdy,
  input  logic                         issue_ack,
  output logic [PAYLOAD_W-1:0]         issue_payload,
  output logic [DATA_W-1:0]            issue_rs1_data,
  output logic [DATA_W-1:0]            issue_rs2_data,
  output logic [TAG_W-1:0]             issue_rd_tag,
  output logic                         dispatch_drop
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic                 valid;
    logic [PAYLOAD_W-1:0] payload;
    logic [DATA_W-1:0]    rs1_data;
    logic                 rs1_valid;
    logic [TAG_W-1:0]     rs1_tag;
    logic [DATA_W-1:0]    rs2_data;
    logic                 rs2_valid;
    logic [TAG_W-1:0]     rs2_tag;
    logic [TAG_W-1:0]     rd_tag;
  } rsq_entry_t;

  rsq_entry_t       entries_q [DEPTH];
  rsq_entry_t       entries_d [DEPTH];
  rsq_entry_t       up_entry  [DEPTH];
  rsq_entry_t       new_entry;
  logic [CNT_W-1:0] count_q, count_d;
  logic             drop_q, drop_d;

  logic [DEPTH-1:0] rs1_hit, rs2_hit, ready_vec, grant, shift_mask;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;
  logic             issue_fire;
  logic             dispatch_ok;
  logic [CNT_W-1:0] wr_idx;
  logic             fwd1, fwd2;

  // Per-entry CDB tag match against stored (pre-shift) operands.
  always_comb begin
    rs1_hit = '0;
    rs2_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rs1_hit[i] = entries_q[i].valid &
                   rsq_snoop_hit(entries_q[i].rs1_valid, entries_q[i].rs1_tag == cdb_tag, cdb_valid);
      rs2_hit[i] = entries_q[i].valid &
                   rsq_snoop_hit(entries_q[i].rs2_valid, entries_q[i].rs2_tag == cdb_tag, cdb_valid);
    end
  end

  // Readiness per entry; the bypass build also counts this cycle's CDB match.
  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef RSQ_CDB_WAKEUP_BYPASS_EN
      ready_vec[i] = entries_q[i].valid &
                     (entries_q[i].rs1_valid | rs1_hit[i]) &
                     (entries_q[i].rs2_valid | rs2_hit[i]);
`else
      ready_vec[i] = entries_q[i].valid & entries_q[i].rs1_valid & entries_q[i].rs2_valid;
`endif
    end
  end

  rsq_oldest_ready_picker #(
    .N     (DEPTH),
    .IDX_W (IDX_W)
  ) u_picker (
    .ready_i (ready_vec),
    .grant_o (grant),
    .idx_o   (sel_idx),
    .any_o   (sel_any)
  );

  // Selected entry drives the issue port; with nothing ready the index is 0.
  always_comb begin
    issue_payload  = entries_q[sel_idx].payload;
    issue_rd_tag   = entries_q[sel_idx].rd_tag;
    issue_rs1_data = entries_q[sel_idx].rs1_data;
    issue_rs2_data = entries_q[sel_idx].rs2_data;
`ifdef RSQ_CDB_WAKEUP_BYPASS_EN
    if (rs1_hit[sel_idx]) issue_rs1_data = cdb_result;
    if (rs2_hit[sel_idx]) issue_rs2_data = cdb_result;
`endif
  end

  assign queue_full    = (count_q == CNT_W'(DEPTH));
  assign queue_empty   = (count_q == '0);
  assign count         = count_q;
  assign issue_rdy     = sel_any;
  assign dispatch_drop = drop_q;

  // Flush overrides every other action; fullness uses the registered count only.
  assign issue_fire  = sel_any & issue_ack & ~flush;
  assign dispatch_ok = dispatch_en & ~queue_full & ~flush;
  assign wr_idx      = count_q - CNT_W'(issue_fire);

  // Entries at and above the issued slot take their younger neighbour.
  always_comb begin
    logic acc;
    acc        = 1'b0;
    shift_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      acc           = acc | grant[i];
      shift_mask[i] = acc & issue_fire;
    end
  end

  // Neighbour-above view; the top slot pulls in an empty entry.
  for (genvar g = 0; g < DEPTH; g++) begin : g_up
    if (g < DEPTH - 1) begin : g_mid
      assign up_entry[g] = entries_q[g+1];
    end else begin : g_top
      assign up_entry[g] = '0;
    end
  end

  // Incoming entry, with same-cycle CDB forwarding for waiting operands.
  always_comb begin
    fwd1                = rsq_snoop_hit(dispatch_rs1_valid, dispatch_rs1_tag == cdb_tag, cdb_valid);
    fwd2                = rsq_snoop_hit(dispatch_rs2_valid, dispatch_rs2_tag == cdb_tag, cdb_valid);
    new_entry           = '0;
    new_entry.valid     = 1'b1;
    new_entry.payload   = dispatch_payload;
    new_entry.rs1_valid = dispatch_rs1_valid | fwd1;
    new_entry.rs1_data  = fwd1 ? cdb_result : dispatch_rs1_data;
    new_entry.rs1_tag   = dispatch_rs1_tag;
    new_entry.rs2_valid = dispatch_rs2_valid | fwd2;
    new_entry.rs2_data  = fwd2 ? cdb_result : dispatch_rs2_data;
    new_entry.rs2_tag   = dispatch_rs2_tag;
    new_entry.rd_tag    = dispatch_rd_tag;
  end

  // Next entry state: shift, then CDB capture on the post-shift slot, then dispatch, then flush.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = shift_mask[i] ? up_entry[i] : entries_q[i];
      if (entries_d[i].valid &&
          rsq_snoop_hit(entries_d[i].rs1_valid, entries_d[i].rs1_tag == cdb_tag, cdb_valid)) begin
        entries_d[i].rs1_valid = 1'b1;
        entries_d[i].rs1_data  = cdb_result;
      end
      if (entries_d[i].valid &&
          rsq_snoop_hit(entries_d[i].rs2_valid, entries_d[i].rs2_tag == cdb_tag, cdb_valid)) begin
        entries_d[i].rs2_valid = 1'b1;
        entries_d[i].rs2_data  = cdb_result;
      end
      if (dispatch_ok && (CNT_W'(i) == wr_idx)) begin
        entries_d[i] = new_entry;
      end
      if (flush) begin
        entries_d[i].valid = 1'b0;
      end
    end
  end

  // Occupancy and the dispatch-while-full error pulse.
  always_comb begin
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(dispatch_ok) - CNT_W'(issue_fire);
    end
    drop_d = dispatch_en & queue_full;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_rsv_station_queue.sv
// Directed bench for rsv_station_queue (DEPTH=4, TAG_W=6, DATA_W=32, PAYLOAD_W=17).
module tb_rsv_station_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        dispatch_en;
  logic [16:0] dispatch_payload;
  logic [31:0] dispatch_rs1_data, dispatch_rs2_data;
  logic        dispatch_rs1_valid, dispatch_rs2_valid;
  logic [5:0]  dispatch_rs1_tag, dispatch_rs2_tag, dispatch_rd_tag;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_result;
  logic        queue_full, queue_empty;
  logic [2:0]  count;
  logic        issue_rdy, issue_ack;
  logic [16:0] issue_payload;
  logic [31:0] issue_rs1_data, issue_rs2_data;
  logic [5:0]  issue_rd_tag;
  logic        dispatch_drop;

  int n_cmp = 0;
  int n_bad = 0;

  rsv_station_queue #(
    .DEPTH(4), .TAG_W(6), .DATA_W(32), .PAYLOAD_W(17)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dispatch_en(dispatch_en), .dispatch_payload(dispatch_payload),
    .dispatch_rs1_data(dispatch_rs1_data), .dispatch_rs2_data(dispatch_rs2_data),
    .dispatch_rs1_valid(dispatch_rs1_valid), .dispatch_rs2_valid(dispatch_rs2_valid),
    .dispatch_rs1_tag(dispatch_rs1_tag), .dispatch_rs2_tag(dispatch_rs2_tag),
    .dispatch_rd_tag(dispatch_rd_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_result(cdb_result),
    .queue_full(queue_full), .queue_empty(queue_empty), .count(count),
    .issue_rdy(issue_rdy), .issue_ack(issue_ack),
    .issue_payload(issue_payload), .issue_rs1_data(issue_rs1_data),
    .issue_rs2_data(issue_rs2_data), .issue_rd_tag(issue_rd_tag),
    .dispatch_drop(dispatch_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_disp(input logic [5:0] rd, input logic [16:0] pay,
                          input logic r1v, input logic [5:0] r1t, input logic [31:0] r1d,
                          input logic r2v, input logic [5:0] r2t, input logic [31:0] r2d);
    dispatch_en        = 1'b1;
    dispatch_rd_tag    = rd;
    dispatch_payload   = pay;
    dispatch_rs1_valid = r1v;
    dispatch_rs1_tag   = r1t;
    dispatch_rs1_data  = r1d;
    dispatch_rs2_valid = r2v;
    dispatch_rs2_tag   = r2t;
    dispatch_rs2_data  = r2d;
  endtask

  task automatic clr_disp();
    dispatch_en        = 1'b0;
    dispatch_rd_tag    = '0;
    dispatch_payload   = '0;
    dispatch_rs1_valid = 1'b0;
    dispatch_rs1_tag   = '0;
    dispatch_rs1_data  = '0;
    dispatch_rs2_valid = 1'b0;
    dispatch_rs2_tag   = '0;
    dispatch_rs2_data  = '0;
  endtask

  initial begin
    int exp4 [3];
    exp4 = '{33, 34, 37};

    rst_n = 1'b0; flush = 1'b0; issue_ack = 1'b0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_result = '0;
    clr_disp();
    tick(); tick();

    // Reset state
    chk("rst_count", count, 0);
    chk("rst_empty", queue_empty, 1);
    chk("rst_full", queue_full, 0);
    chk("rst_issue_rdy", issue_rdy, 0);
    chk("rst_drop", dispatch_drop, 0);
    chk("rst_payload", issue_payload, 0);
    rst_n = 1'b1;

    // Four ready entries, drained in order with ack held high
    for (int k = 1; k <= 4; k++) begin
      set_disp(6'(k), 17'(32'h100 + k), 1'b1, 6'd0, 32'(k), 1'b1, 6'd0, 32'(k + 16));
      tick();
      if (k == 1) begin
        chk("t1_latency_rdy", issue_rdy, 1);
        chk("t1_latency_tag", issue_rd_tag, 1);
      end
    end
    clr_disp();
    settle();
    chk("t1_count4", count, 4);
    chk("t1_full", queue_full, 1);
    chk("t1_not_empty", queue_empty, 0);
    issue_ack = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      settle();
      chk("t1_issue_tag", issue_rd_tag, k);
      chk("t1_issue_payload", issue_payload, 32'h100 + k);
      chk("t1_issue_rs2", issue_rs2_data, k + 16);
      tick();
      chk("t1_count", count, 4 - k);
    end
    issue_ack = 1'b0;
    settle();
    chk("t1_empty", queue_empty, 1);
    chk("t1_rdy0", issue_rdy, 0);

    // Younger ready entry bypasses an older waiting one; CDB then wakes the older
    set_disp(6'd10, 17'h10, 1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'd2);
    tick();
    set_disp(6'd11, 17'h11, 1'b1, 6'd0, 32'h11, 1'b1, 6'd0, 32'h22);
    tick();
    clr_disp();
    settle();
    chk("t2_rdy", issue_rdy, 1);
    chk("t2_sel_b", issue_rd_tag, 11);
    tick(); tick();
    chk("t2_hold_b", issue_rd_tag, 11);
    chk("t2_hold_count", count, 2);
    issue_ack = 1'b1;
    settle();
    tick();
    issue_ack = 1'b0;
    settle();
    chk("t2_count1", count, 1);
    chk("t2_a_waits", issue_rdy, 0);
    cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_result = 32'hDEADBEEF;
    settle();
`ifdef RSQ_CDB_WAKEUP_BYPASS_EN
    chk("t2_cdb_cycle_rdy", issue_rdy, 1);
`else
    chk("t2_cdb_cycle_rdy", issue_rdy, 0);
`endif
    tick();
    cdb_valid = 1'b0; cdb_tag = '0; cdb_result = '0;
    settle();
    chk("t2_a_rdy", issue_rdy, 1);
    chk("t2_a_tag", issue_rd_tag, 10);
    chk("t2_a_rs1", issue_rs1_data, 32'hDEADBEEF);
    chk("t2_a_rs2", issue_rs2_data, 2);
    issue_ack = 1'b1;
    tick();
    issue_ack = 1'b0;
    settle();
    chk("t2_empty", queue_empty, 1);

    // Dispatch-time forwarding from a same-cycle CDB broadcast
    set_disp(6'd20, 17'h20, 1'b1, 6'd0, 32'd7, 1'b0, 6'd5, 32'd0);
    cdb_valid = 1'b1; cdb_tag = 6'd5; cdb_result = 32'h1234;
    tick();
    clr_disp();
    cdb_valid = 1'b0; cdb_tag = '0; cdb_result = '0;
    settle();
    chk("t3_rdy", issue_rdy, 1);
    chk("t3_tag", issue_rd_tag, 20);
    chk("t3_rs2_fwd", issue_rs2_data, 32'h1234);
    chk("t3_rs1", issue_rs1_data, 7);
    issue_ack = 1'b1;
    tick();
    issue_ack = 1'b0;
    settle();
    chk("t3_empty", queue_empty, 1);

    // Full queue: drops, including a dispatch alongside an issue while full
    for (int k = 31; k <= 34; k++) begin
      set_disp(6'(k), 17'(k), 1'b1, 6'd0, 32'(k), 1'b1, 6'd0, 32'(k));
      tick();
    end
    set_disp(6'd35, 17'd35, 1'b1, 6'd0, 32'd35, 1'b1, 6'd0, 32'd35);
    tick();
    chk("t4_drop", dispatch_drop, 1);
    chk("t4_count_full", count, 4);
    set_disp(6'd36, 17'd36, 1'b1, 6'd0, 32'd36, 1'b1, 6'd0, 32'd36);
    issue_ack = 1'b1;
    settle();
    chk("t4_issue31", issue_rd_tag, 31);
    tick();
    chk("t4_count_after_full_ack", count, 3);
    chk("t4_drop_full_ack", dispatch_drop, 1);
    set_disp(6'd37, 17'd37, 1'b1, 6'd0, 32'd37, 1'b1, 6'd0, 32'd37);
    settle();
    chk("t4_issue32", issue_rd_tag, 32);
    tick();
    clr_disp();
    issue_ack = 1'b0;
    settle();
    chk("t4_count_same", count, 3);
    chk("t4_drop_clear", dispatch_drop, 0);
    issue_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t4_order", issue_rd_tag, exp4[k]);
      tick();
    end
    issue_ack = 1'b0;
    settle();
    chk("t4_empty", queue_empty, 1);

    // Flush beats dispatch, issue and CDB capture
    set_disp(6'd41, 17'd41, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1);
    tick();
    set_disp(6'd42, 17'd42, 1'b0, 6'd12, 32'd0, 1'b1, 6'd0, 32'd1);
    tick();
    set_disp(6'd43, 17'd43, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1);
    tick();
    chk("t5_count3", count, 3);
    set_disp(6'd44, 17'd44, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1);
    issue_ack = 1'b1;
    flush = 1'b1;
    cdb_valid = 1'b1; cdb_tag = 6'd12; cdb_result = 32'hAA;
    tick();
    clr_disp();
    issue_ack = 1'b0;
    flush = 1'b0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_result = '0;
    settle();
    chk("t5_count0", count, 0);
    chk("t5_rdy0", issue_rdy, 0);
    chk("t5_empty", queue_empty, 1);
    set_disp(6'd45, 17'd45, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd6);
    tick();
    clr_disp();
    settle();
    chk("t5_post_count", count, 1);
    chk("t5_post_tag", issue_rd_tag, 45);
    issue_ack = 1'b1;
    tick();
    issue_ack = 1'b0;

    // Reset mid-operation also suppresses the drop pulse
    for (int k = 51; k <= 54; k++) begin
      set_disp(6'(k), 17'(k), 1'b1, 6'd0, 32'(k), 1'b1, 6'd0, 32'(k));
      tick();
    end
    set_disp(6'd55, 17'd55, 1'b1, 6'd0, 32'd55, 1'b1, 6'd0, 32'd55);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clr_disp();
    settle();
    chk("t6_count0", count, 0);
    chk("t6_drop0", dispatch_drop, 0);
    chk("t6_empty", queue_empty, 1);
    chk("t6_rdy0", issue_rdy, 0);

`ifdef RSQ_CDB_WAKEUP_BYPASS_EN
    // Zero-cycle wakeup
    set_disp(6'd60, 17'd60, 1'b0, 6'd7, 32'd0, 1'b1, 6'd0, 32'd3);
    tick();
    clr_disp();
    cdb_valid = 1'b1; cdb_tag = 6'd7; cdb_result = 32'h55;
    settle();
    chk("t7_bypass_rdy", issue_rdy, 1);
    chk("t7_bypass_rs1", issue_rs1_data, 32'h55);
    tick();
    cdb_valid = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
